// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Pipeline hazard/stall controller for the 5-stage RISC-V core, placed between
// the ID and EX stages. Each cycle it picks one of four output modes, checked
// in this order:
//   FLUSH  (taken branch)   clears IF/ID and injects a NOP into ID/EX
//   FREEZE (mul/div busy)   holds PC, IF/ID and ID/EX
//   BUBBLE (load-use)       holds PC and IF/ID, injects a NOP into ID/EX
//   NORMAL                  everything advances
// A load-use hit produces exactly LOAD_BUBBLES bubbles. The first bubble is
// issued in the same cycle the hit is seen; any further bubbles are counted
// down in the LSTALL state.
//
// Parameters
//   REG_AW        register address width
//   LOAD_BUBBLES  bubbles per load-use hit (0..4), 0 disables load-use stalls
//   PERF_W        width of the optional performance counters
//
// Ports
//   clk           core clock, rising edge
//   reset         asynchronous, active-low reset
//   ex_rd         destination register of the instruction in EX
//   ex_mem_read   instruction in EX is a load
//   id_rs1/rs2    source registers decoded in ID
//   id_use_rs1/2  ID instruction actually reads rs1 / rs2
//   md_busy       mul/div unit in EX has not finished
//   branch_taken  branch/jump resolved taken in EX
//   PCwrite       PC register write enable
//   IF_IDwrite    IF/ID pipeline register write enable
//   ID_EXwrite    ID/EX pipeline register write enable
//   control_sel   1 = inject NOP controls into ID/EX
//   flush_if_id   1 = clear IF/ID to NOP on the next edge
//   stall_cnt     (HAZ_PERF_CNT_EN) saturating count of BUBBLE/FREEZE cycles
//   flush_cnt     (HAZ_PERF_CNT_EN) saturating count of FLUSH cycles
//
// Optional feature: define HAZ_PERF_CNT_EN to add the stall_cnt / flush_cnt
// ports and their counters. Without it the control behaviour is identical.
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
   parameter int REG_AW       = 5,
   parameter int LOAD_BUBBLES = 1,
   parameter int PERF_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              md_busy,
   input  logic              branch_taken,
   output logic              PCwrite,
   output logic              IF_IDwrite,
   output logic              ID_EXwrite,
   output logic              control_sel,
   output logic              flush_if_id
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt
`endif
);

   // A single-bit counter is kept even when it is never used, so that no
   // zero-width vectors appear for LOAD_BUBBLES of 0 or 1.
   localparam int CNT_W = (LOAD_BUBBLES < 2) ? 1 : $clog2(LOAD_BUBBLES + 1);

   localparam bit LU_EN   = (LOAD_BUBBLES > 0);   // load-use stalling enabled
   localparam bit LU_MULT = (LOAD_BUBBLES > 1);   // more than one bubble per hit

   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LU_MULT ? LOAD_BUBBLES - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   generate
      if (LOAD_BUBBLES < 0 || LOAD_BUBBLES > 4) begin : g_bad_load_bubbles
         $error("hazard_stall_ctrl: LOAD_BUBBLES must be in 0..4");
      end
   endgenerate

   typedef enum logic {
      S_IDLE,
      S_LSTALL
   } state_t;

   typedef enum logic [1:0] {
      M_NORMAL,
      M_BUBBLE,
      M_FREEZE,
      M_FLUSH
   } mode_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   mode_t            mode;
   logic             hit;

   // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
   assign hit = ex_mem_read && (ex_rd != '0) &&
                ((id_use_rs1 && (ex_rd == id_rs1)) ||
                 (id_use_rs2 && (ex_rd == id_rs2)));

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of block order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: every variable gets a default at the top of a combinational block,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (branch_taken) begin
         // A taken branch throws away the dependent instruction, so any
         // pending load stall is abandoned.
         state_nx = S_IDLE;
         cnt_nx   = '0;
      end else if (md_busy) begin
         // Pipeline frozen: the remaining bubble count is preserved.
         state_nx = state;
         cnt_nx   = cnt;
      end else if (state == S_LSTALL) begin
         cnt_nx = cnt - CNT_ONE;
         if (cnt == CNT_ONE) begin
            state_nx = S_IDLE;
         end
      end else if (hit && LU_MULT) begin
         // The first bubble is issued this cycle; the rest are counted down.
         state_nx = S_LSTALL;
         cnt_nx   = CNT_RELOAD;
      end
   end

   // -------------------------------------------------------------------------
   // Output logic
   // -------------------------------------------------------------------------
   always_comb begin
      mode = M_NORMAL;
      if (branch_taken) begin
         mode = M_FLUSH;
      end else if (md_busy) begin
         mode = M_FREEZE;
      end else if (state == S_LSTALL) begin
         mode = M_BUBBLE;
      end else if (hit && LU_EN) begin
         mode = M_BUBBLE;
      end

      PCwrite     = 1'b1;
      IF_IDwrite  = 1'b1;
      ID_EXwrite  = 1'b1;
      control_sel = 1'b0;
      flush_if_id = 1'b0;
      unique case (mode)
         M_FLUSH: begin
            control_sel = 1'b1;
            flush_if_id = 1'b1;
         end
         M_FREEZE: begin
            PCwrite    = 1'b0;
            IF_IDwrite = 1'b0;
            ID_EXwrite = 1'b0;
         end
         M_BUBBLE: begin
            PCwrite     = 1'b0;
            IF_IDwrite  = 1'b0;
            control_sel = 1'b1;
         end
         default: ;
      endcase

      // While reset is held the pipeline sees a safe bubble, so nothing
      // advances and no stray control reaches EX.
      if (!reset) begin
         PCwrite     = 1'b0;
         IF_IDwrite  = 1'b0;
         ID_EXwrite  = 1'b1;
         control_sel = 1'b1;
         flush_if_id = 1'b0;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   // -------------------------------------------------------------------------
   // Saturating performance counters
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if ((mode == M_BUBBLE || mode == M_FREEZE) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if ((mode == M_FLUSH) && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Three instances share one stimulus stream: LOAD_BUBBLES = 3, 1 and 0.
// The reference model tracks only "bubbles still owed" per instance and
// derives each cycle's output mode from the priority rules. With
// HAZ_PERF_CNT_EN the counters (PERF_W = 4) are modelled as saturating sums.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

   localparam int AW = 5;
   localparam int PW = 4;
   localparam int ND = 3;

   // {PCwrite, IF_IDwrite, ID_EXwrite, control_sel, flush_if_id}
   localparam logic [4:0] O_FLUSH  = 5'b11111;
   localparam logic [4:0] O_FREEZE = 5'b00000;
   localparam logic [4:0] O_BUBBLE = 5'b00110;
   localparam logic [4:0] O_NORMAL = 5'b11100;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] ex_rd;
   logic          ex_mem_read;
   logic [AW-1:0] id_rs1, id_rs2;
   logic          id_use_rs1, id_use_rs2;
   logic          md_busy, branch_taken;

   logic          pc [ND];
   logic          ifid [ND];
   logic          idex [ND];
   logic          csel [ND];
   logic          fl [ND];
   logic [PW-1:0] scnt [ND];
   logic [PW-1:0] fcnt [ND];

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.REG_AW(AW), .LOAD_BUBBLES(3), .PERF_W(PW)) dut_lb3 (
      .clk(clk), .reset(reset), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .md_busy(md_busy), .branch_taken(branch_taken),
      .PCwrite(pc[0]), .IF_IDwrite(ifid[0]), .ID_EXwrite(idex[0]),
      .control_sel(csel[0]), .flush_if_id(fl[0])
`ifdef HAZ_PERF_CNT_EN
      , .stall_cnt(scnt[0]), .flush_cnt(fcnt[0])
`endif
   );

   hazard_stall_ctrl #(.REG_AW(AW), .LOAD_BUBBLES(1), .PERF_W(PW)) dut_lb1 (
      .clk(clk), .reset(reset), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .md_busy(md_busy), .branch_taken(branch_taken),
      .PCwrite(pc[1]), .IF_IDwrite(ifid[1]), .ID_EXwrite(idex[1]),
      .control_sel(csel[1]), .flush_if_id(fl[1])
`ifdef HAZ_PERF_CNT_EN
      , .stall_cnt(scnt[1]), .flush_cnt(fcnt[1])
`endif
   );

   hazard_stall_ctrl #(.REG_AW(AW), .LOAD_BUBBLES(0), .PERF_W(PW)) dut_lb0 (
      .clk(clk), .reset(reset), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .md_busy(md_busy), .branch_taken(branch_taken),
      .PCwrite(pc[2]), .IF_IDwrite(ifid[2]), .ID_EXwrite(idex[2]),
      .control_sel(csel[2]), .flush_if_id(fl[2])
`ifdef HAZ_PERF_CNT_EN
      , .stall_cnt(scnt[2]), .flush_cnt(fcnt[2])
`endif
   );

   typedef struct {
      logic       rst_n;
      int         rd;
      logic       mr;
      int         rs1;
      logic       u1;
      int         rs2;
      logic       u2;
      logic       busy;
      logic       br;
      logic [4:0] e [ND];   // expected outputs for LOAD_BUBBLES 3, 1, 0
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int lbs [ND]   = '{3, 1, 0};
   int owed [ND]  = '{0, 0, 0};
   int m_scnt [ND] = '{0, 0, 0};
   int m_fcnt [ND] = '{0, 0, 0};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit r, input int rd, input bit mr, input int rs1,
                               input bit u1, input int rs2, input bit u2, input bit busy,
                               input bit br, input logic [4:0] e3, input logic [4:0] e1,
                               input logic [4:0] e0);
      vec_t v;
      v.rst_n = r; v.rd = rd; v.mr = mr; v.rs1 = rs1; v.u1 = u1;
      v.rs2 = rs2; v.u2 = u2; v.busy = busy; v.br = br;
      v.e[0] = e3; v.e[1] = e1; v.e[2] = e0;
      return v;
   endfunction

   function automatic vec_t nop(input logic [4:0] e3, input logic [4:0] e1, input logic [4:0] e0);
      return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, e3, e1, e0);
   endfunction

   function automatic logic [4:0] dut_out(input int k);
      return {pc[k], ifid[k], idex[k], csel[k], fl[k]};
   endfunction

   function automatic bit model_hit(input vec_t v);
      return v.mr && (v.rd != 0) && ((v.u1 && v.rd == v.rs1) || (v.u2 && v.rd == v.rs2));
   endfunction

   function automatic logic [4:0] model_mode(input vec_t v, input int k);
      if (!v.rst_n)                          return O_BUBBLE;
      if (v.br)                              return O_FLUSH;
      if (v.busy)                            return O_FREEZE;
      if (owed[k] > 0)                       return O_BUBBLE;
      if (model_hit(v) && lbs[k] > 0)        return O_BUBBLE;
      return O_NORMAL;
   endfunction

   // Applies one cycle of inputs, compares at the falling edge, advances the
   // model, then waits for the rising edge.
   task automatic step(input string name, input vec_t v, input bit use_tab);
      logic [4:0] m;
      reset        = v.rst_n;
      ex_rd        = AW'(v.rd);
      ex_mem_read  = v.mr;
      id_rs1       = AW'(v.rs1);
      id_rs2       = AW'(v.rs2);
      id_use_rs1   = v.u1;
      id_use_rs2   = v.u2;
      md_busy      = v.busy;
      branch_taken = v.br;
      @(negedge clk);
      for (int k = 0; k < ND; k++) begin
         m = model_mode(v, k);
         if (use_tab) check($sformatf("%s lb%0d", name, lbs[k]), 32'(dut_out(k)), 32'(v.e[k]));
         else         check($sformatf("%s lb%0d", name, lbs[k]), 32'(dut_out(k)), 32'(m));
`ifdef HAZ_PERF_CNT_EN
         if (!v.rst_n) begin
            m_scnt[k] = 0;
            m_fcnt[k] = 0;
         end
         check($sformatf("%s stall_cnt lb%0d", name, lbs[k]), 32'(scnt[k]), 32'(m_scnt[k]));
         check($sformatf("%s flush_cnt lb%0d", name, lbs[k]), 32'(fcnt[k]), 32'(m_fcnt[k]));
         if (v.rst_n) begin
            if ((m == O_BUBBLE || m == O_FREEZE) && m_scnt[k] < (1 << PW) - 1) m_scnt[k]++;
            if (m == O_FLUSH && m_fcnt[k] < (1 << PW) - 1) m_fcnt[k]++;
         end
`endif
         if (!v.rst_n || v.br)                   owed[k] = 0;
         else if (v.busy)                        owed[k] = owed[k];
         else if (owed[k] > 0)                   owed[k] = owed[k] - 1;
         else if (model_hit(v) && lbs[k] > 0)    owed[k] = lbs[k] - 1;
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tab[$];
   vec_t v;

   initial begin
      // Reset, T1 (single hit), T2 (x0 / unused sources), T3 (3-bubble hit,
      // repeated hit ignored while stalling).
      tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUBBLE, O_BUBBLE, O_BUBBLE));
      tab.push_back(mk(0, 5, 1, 5, 1, 0, 0, 0, 0, O_BUBBLE, O_BUBBLE, O_BUBBLE));
      tab.push_back(nop(O_NORMAL, O_NORMAL, O_NORMAL));
      tab.push_back(mk(1, 5, 1, 5, 1, 0, 0, 0, 0, O_BUBBLE, O_BUBBLE, O_NORMAL));
      tab.push_back(nop(O_BUBBLE, O_NORMAL, O_NORMAL));
      tab.push_back(nop(O_BUBBLE, O_NORMAL, O_NORMAL));
      tab.push_back(nop(O_NORMAL, O_NORMAL, O_NORMAL));
      tab.push_back(mk(1, 0, 1, 0, 1, 0, 1, 0, 0, O_NORMAL, O_NORMAL, O_NORMAL));
      tab.push_back(mk(1, 5, 1, 5, 0, 5, 0, 0, 0, O_NORMAL, O_NORMAL, O_NORMAL));
      tab.push_back(mk(1, 5, 1, 3, 1, 5, 0, 0, 0, O_NORMAL, O_NORMAL, O_NORMAL));
      tab.push_back(mk(1, 5, 0, 5, 1, 5, 1, 0, 0, O_NORMAL, O_NORMAL, O_NORMAL));
      tab.push_back(mk(1, 7, 1, 2, 1, 7, 1, 0, 0, O_BUBBLE, O_BUBBLE, O_NORMAL));
      tab.push_back(nop(O_BUBBLE, O_NORMAL, O_NORMAL));
      tab.push_back(mk(1, 7, 1, 2, 1, 7, 1, 0, 0, O_BUBBLE, O_BUBBLE, O_NORMAL));
      tab.push_back(nop(O_NORMAL, O_NORMAL, O_NORMAL));
      tab.push_back(mk(1, 31, 1, 31, 1, 0, 0, 0, 0, O_BUBBLE, O_BUBBLE, O_NORMAL));
      tab.push_back(nop(O_BUBBLE, O_NORMAL, O_NORMAL));
      tab.push_back(nop(O_BUBBLE, O_NORMAL, O_NORMAL));
      tab.push_back(nop(O_NORMAL, O_NORMAL, O_NORMAL));
      for (int i = 0; i < tab.size(); i++) step($sformatf("tab[%0d]", i), tab[i], 1);

      // T4: taken branch in the 2nd stall cycle aborts the remaining bubble.
      step("t4 hit",    mk(1, 7, 1, 0, 0, 7, 1, 0, 0, O_BUBBLE, O_BUBBLE, O_NORMAL), 1);
      step("t4 stall2", nop(O_BUBBLE, O_NORMAL, O_NORMAL), 1);
      step("t4 branch", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, O_FLUSH, O_FLUSH, O_FLUSH), 1);
      step("t4 after",  nop(O_NORMAL, O_NORMAL, O_NORMAL), 1);

      // T5: mul/div busy freezes the stall counter at 2 for 4 cycles.
      step("t5 hit", mk(1, 9, 1, 9, 1, 0, 0, 0, 0, O_BUBBLE, O_BUBBLE, O_NORMAL), 1);
      for (int i = 0; i < 4; i++)
         step($sformatf("t5 busy%0d", i), mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_FREEZE, O_FREEZE, O_FREEZE), 1);
      step("t5 rem1", nop(O_BUBBLE, O_NORMAL, O_NORMAL), 1);
      step("t5 rem2", nop(O_BUBBLE, O_NORMAL, O_NORMAL), 1);
      step("t5 done", nop(O_NORMAL, O_NORMAL, O_NORMAL), 1);

      // Branch outranks busy; busy outranks a fresh hit.
      step("prio br>busy",  mk(1, 4, 1, 4, 1, 0, 0, 1, 1, O_FLUSH, O_FLUSH, O_FLUSH), 1);
      step("prio busy>hit", mk(1, 4, 1, 4, 1, 0, 0, 1, 0, O_FREEZE, O_FREEZE, O_FREEZE), 1);
      step("prio hit",      mk(1, 4, 1, 4, 1, 0, 0, 0, 0, O_BUBBLE, O_BUBBLE, O_NORMAL), 1);

      // T6: reset for 2 cycles in the middle of a load stall.
      step("t6 rst0", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUBBLE, O_BUBBLE, O_BUBBLE), 1);
      step("t6 rst1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUBBLE, O_BUBBLE, O_BUBBLE), 1);
      step("t6 rel",  nop(O_NORMAL, O_NORMAL, O_NORMAL), 1);

      // Randomized traffic against the model; small register range makes
      // hits frequent, and long runs drive the 4-bit counters into saturation.
      for (int i = 0; i < 600; i++) begin
         v = mk(($urandom_range(0, 59) != 0),
                int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
                O_NORMAL, O_NORMAL, O_NORMAL);
         step($sformatf("rnd[%0d]", i), v, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
